mem_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the processor's shared instruction/data memory (1024 x 32-bit words). It grants one request at a time between the instruction-fetch port (F) and the load/store data port (D). For the granted request it issues a single memory access, waits the fixed memory latency, and returns the read data with a one-cycle acknowledge. Data requests normally win, and a starvation guard guarantees forward progress for fetch.

---
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: fetch/data arbiter and single-access sequencer for shared memory.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of D priority + starvation guard.
module mem_port_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_ack,
  output logic [DW-1:0] f_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam int LW = $clog2(MEM_LAT + 1);

  state_t        r_state;
  logic          r_own_d;
  logic          r_we;
  logic [LW-1:0] r_lat;
  logic          w_any;
  logic          w_pick_d;

  assign w_any = f_req | d_req;

`ifdef MEM_ARB_RR_EN
  // r_last_d: 1 when D held the most recent grant
  logic r_last_d;

  always_comb begin
    w_pick_d = d_req & (~f_req | ~r_last_d);
  end
`else
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] r_starve;

  always_comb begin
    w_pick_d = d_req &
      (~f_req | (r_starve != SW'(STARVE_MAX)));
  end
`endif

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_own_d   <= 1'b0;
      r_we      <= 1'b0;
      r_lat     <= '0;
      f_ack     <= 1'b0;
      d_ack     <= 1'b0;
      f_rdata   <= '0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
`ifdef MEM_ARB_RR_EN
      r_last_d  <= 1'b0;
`else
      r_starve  <= '0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_own_d   <= w_pick_d;
            r_we      <= w_pick_d & d_we;
            mem_we    <= w_pick_d & d_we;
            mem_addr  <= w_pick_d ? d_addr : f_addr;
            mem_wdata <= w_pick_d ? d_wdata : '0;
            mem_en    <= 1'b1;
            busy      <= 1'b1;
            r_state   <= S_ISSUE;
`ifdef MEM_ARB_RR_EN
            r_last_d  <= w_pick_d;
`endif
          end
`ifndef MEM_ARB_RR_EN
          // counts D wins only while F is left waiting
          if (!f_req || !w_pick_d) begin
            r_starve <= '0;
          end else if (r_starve != SW'(STARVE_MAX)) begin
            r_starve <= r_starve + 1'b1;
          end
`endif
        end
        S_ISSUE: begin
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
          r_lat   <= LW'(MEM_LAT);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_lat == LW'(1)) begin
            if (r_own_d) begin
              d_rdata <= r_we ? '0 : mem_rdata;
              d_ack   <= 1'b1;
            end else begin
              f_rdata <= mem_rdata;
              f_ack   <= 1'b1;
            end
            r_state <= S_DONE;
          end else begin
            r_lat <= r_lat - 1'b1;
          end
        end
        S_DONE: begin
          f_ack   <= 1'b0;
          d_ack   <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter
// against a transaction-level model of grants, timing and memory contents.
module tb_mem_port_arbiter;

  localparam int L  = 3;
  localparam int SM = 4;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk1 = 1'b0;
  logic          rst;
  logic          f_req, d_req, d_we;
  logic [AW-1:0] f_addr, d_addr, mem_addr;
  logic [DW-1:0] d_wdata, f_rdata, d_rdata;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          f_ack, d_ack, mem_en, mem_we, busy;

  always #5 clk1 = ~clk1;

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .MEM_LAT(L), .STARVE_MAX(SM)
  ) dut (
    .clk1(clk1), .rst(rst),
    .f_req(f_req), .f_addr(f_addr),
    .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  function automatic logic [31:0] init_val(input int a);
    if (a == 5) return 32'hDEADBEEF;
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // memory device: registered read, L cycles after mem_en
  logic [DW-1:0] dmem [1024];
  logic [DW-1:0] pipe [L];

  always @(posedge clk1) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) dmem[i] <= init_val(i);
    end else if (mem_en && mem_we) begin
      dmem[mem_addr] <= mem_wdata;
    end
    pipe[0] <= mem_en ?
      (mem_we ? 32'hBAD0BAD0 : dmem[mem_addr]) : $urandom;
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end

  assign mem_rdata = pipe[L-1];

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
  endtask

  task automatic fail(input string nm);
    n_chk++;
    $display("FAIL %s: bound expired at %0t", nm, $time);
  endtask

  // inputs as seen at each rising edge
  bit            s_rst = 1'b1;
  bit            s_freq, s_dreq, s_dwe;
  logic [AW-1:0] s_faddr, s_daddr;
  logic [DW-1:0] s_dwd;

  always @(posedge clk1) begin
    s_rst = rst;
    s_freq = f_req;
    s_dreq = d_req;
    s_dwe = d_we;
    s_faddr = f_addr;
    s_daddr = d_addr;
    s_dwd = d_wdata;
  end

  // transaction model: a grant at edge t0 fixes every output by (edge - t0)
  logic [DW-1:0] refmem [1024];
  int            ecyc, m_t0, m_scnt;
  int            m_k = -1;
  bit            m_act, m_own_d, m_we, m_last_d;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd, m_rd;

  always @(negedge clk1) begin
    bit g_d;
    bit fa, da;
    if (rst || s_rst) begin
      m_act = 0; m_scnt = 0; m_last_d = 0; ecyc = 0; m_k = -1;
      for (int i = 0; i < 1024; i++) refmem[i] = init_val(i);
      chk1("rst f_ack", f_ack, 1'b0);
      chk1("rst d_ack", d_ack, 1'b0);
      chk1("rst mem_en", mem_en, 1'b0);
      chk1("rst mem_we", mem_we, 1'b0);
      chk1("rst busy", busy, 1'b0);
      chk("rst f_rdata", f_rdata, 32'h0);
      chk("rst d_rdata", d_rdata, 32'h0);
      chk("rst mem_addr", 32'(mem_addr), 32'h0);
      chk("rst mem_wdata", mem_wdata, 32'h0);
    end else begin
      ecyc++;
      if (!m_act || ecyc - m_t0 >= L + 3) begin
        m_act = 0;
        g_d = 0;
`ifdef MEM_ARB_RR_EN
        g_d = s_dreq && (!s_freq || !m_last_d);
        if (s_freq || s_dreq) m_last_d = g_d;
`else
        g_d = s_dreq && (!s_freq || m_scnt != SM);
        if (s_freq && g_d) m_scnt = (m_scnt < SM) ? m_scnt + 1 : SM;
        else m_scnt = 0;
`endif
        if (s_freq || s_dreq) begin
          m_act = 1;
          m_t0 = ecyc;
          m_own_d = g_d;
          m_addr = g_d ? s_daddr : s_faddr;
          m_we = g_d && s_dwe;
          m_wd = s_dwd;
          m_rd = m_we ? '0 : refmem[m_addr];
          if (m_we) refmem[m_addr] = m_wd;
        end
      end
      m_k = m_act ? ecyc - m_t0 : -1;
      fa = (m_k == L + 1) && !m_own_d;
      da = (m_k == L + 1) && m_own_d;
      chk1("busy", busy, m_k >= 0 && m_k <= L + 1);
      chk1("mem_en", mem_en, m_k == 0);
      chk1("mem_we", mem_we, m_k == 0 && m_we);
      chk1("f_ack", f_ack, fa);
      chk1("d_ack", d_ack, da);
      if (m_k == 0) chk("mem_addr", 32'(mem_addr), 32'(m_addr));
      if (m_k == 0 && m_we) chk("mem_wdata", mem_wdata, m_wd);
      if (fa) chk("f_rdata", f_rdata, m_rd);
      if (da) chk("d_rdata", d_rdata, m_rd);
    end
  end

  // requester side
  bit         f_seen, d_seen, cont_f, cont_d, rnd;
  int         tcount;
  int         ack_n;
  logic [9:0] ack_log;
  int         ack_t[$];

  task automatic new_f();
    f_req = 1;
    f_addr = AW'($urandom);
  endtask

  task automatic new_d();
    d_req = 1;
    d_we = 1'($urandom_range(1));
    d_addr = AW'($urandom);
    d_wdata = $urandom;
  endtask

  task automatic tick();
    @(posedge clk1);
    #2;
    tcount++;
    if (f_ack) begin
      ack_log = {ack_log[8:0], 1'b0};
      ack_n++;
      ack_t.push_back(tcount);
    end
    if (d_ack) begin
      ack_log = {ack_log[8:0], 1'b1};
      ack_n++;
    end
    if (f_seen) begin f_seen = 0; f_req = 0; end
    if (d_seen) begin d_seen = 0; d_req = 0; end
    if (f_req && f_ack) f_seen = 1;
    if (d_req && d_ack) d_seen = 1;
    if (!f_req && !f_seen &&
        (cont_f || (rnd && $urandom_range(3) == 0))) new_f();
    if (!d_req && !d_seen &&
        (cont_d || (rnd && $urandom_range(3) == 0))) new_d();
    // owner's inputs are ignored mid-transaction
    if (rnd && m_act && m_k >= 0 && m_k <= L &&
        $urandom_range(2) == 0) begin
      if (m_own_d) begin
        d_addr = AW'($urandom);
        d_wdata = $urandom;
        d_we = 1'($urandom_range(1));
      end else begin
        f_addr = AW'($urandom);
      end
    end
  endtask

  task automatic wait_ack(input bit is_d, output int lat,
                          output int en_at, output logic [AW-1:0] ea,
                          output logic ew);
    lat = -1; en_at = -1; ea = '0; ew = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (mem_en && en_at < 0) begin
        en_at = i; ea = mem_addr; ew = mem_we;
      end
      if (is_d ? d_ack : f_ack) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) fail("ack wait");
  endtask

  task automatic drain();
    int g = 0;
    while ((f_req || d_req || busy) && g < 80) begin
      tick();
      g++;
    end
    if (g >= 80) fail("drain");
  endtask

  task automatic do_reset();
    rst = 1;
    f_req = 0; d_req = 0; f_seen = 0; d_seen = 0;
    tick();
    tick();
    rst = 0;
  endtask

  initial begin
    int lat, en_at, acks, g;
    logic [AW-1:0] ea;
    logic ew;
    logic [9:0] exp_order;
    rst = 1;
    f_req = 0; d_req = 0; d_we = 0;
    f_addr = '0; d_addr = '0; d_wdata = '0;
    tick();
    tick();
    chk1("reset busy", busy, 1'b0);
    chk1("reset mem_en", mem_en, 1'b0);
    chk("reset f_rdata", f_rdata, 32'h0);
    rst = 0;

    // single fetch from reset
    tick();
    f_req = 1; f_addr = 10'd5;
    wait_ack(0, lat, en_at, ea, ew);
    chk("fetch latency", 32'(lat), 32'(L + 2));
    chk("fetch mem_en cycle", 32'(en_at), 32'd1);
    chk("fetch mem_addr", 32'(ea), 32'd5);
    chk("fetch data", f_rdata, 32'hDEADBEEF);
    chk1("fetch no d_ack", d_ack, 1'b0);

    // store then load at the top address
    tick();
    d_req = 1; d_we = 1; d_addr = 10'h3FF; d_wdata = 32'h12345678;
    wait_ack(1, lat, en_at, ea, ew);
    chk("store latency", 32'(lat), 32'(L + 2));
    chk1("store mem_we", ew, 1'b1);
    chk("store rdata", d_rdata, 32'h0);
    tick();
    d_req = 1; d_we = 0;
    wait_ack(1, lat, en_at, ea, ew);
    chk1("load mem_we", ew, 1'b0);
    chk("load rdata", d_rdata, 32'h12345678);
    drain();

    // both requesting continuously from reset
    do_reset();
    new_f(); new_d();
    cont_f = 1; cont_d = 1;
    ack_n = 0; ack_log = '0; g = 0;
    while (ack_n < 10 && g < 200) begin
      tick();
      g++;
    end
    if (ack_n < 10) fail("grant order");
`ifdef MEM_ARB_RR_EN
    exp_order = 10'b1010101010;
`else
    exp_order = 10'b1111011110;
`endif
    chk("grant order", 32'(ack_log), 32'(exp_order));
    cont_f = 0; cont_d = 0;
    drain();

    // reset in the middle of WAIT
    tick();
    f_req = 1; f_addr = 10'h155;
    en_at = -1;
    for (int i = 0; i < 20 && en_at < 0; i++) begin
      tick();
      if (mem_en) en_at = i;
    end
    if (en_at < 0) fail("mid-wait mem_en");
    tick();
    tick();
    chk1("mid-wait busy", busy, 1'b1);
    rst = 1; f_req = 0; f_seen = 0;
    #1;
    chk1("async rst busy", busy, 1'b0);
    chk1("async rst f_ack", f_ack, 1'b0);
    chk1("async rst mem_en", mem_en, 1'b0);
    chk("async rst mem_addr", 32'(mem_addr), 32'h0);
    tick();
    tick();
    rst = 0;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (f_ack || d_ack) acks++;
    end
    chk("acks after reset", 32'(acks), 32'd0);
    f_req = 1; f_addr = 10'h2A;
    wait_ack(0, lat, en_at, ea, ew);
    chk("post-reset latency", 32'(lat), 32'(L + 2));
    chk("post-reset data", f_rdata, init_val(42));
    drain();

    // back-to-back fetches
    tick();
    ack_t.delete();
    cont_f = 1;
    new_f();
    g = 0;
    while (ack_t.size() < 3 && g < 60) begin
      tick();
      g++;
    end
    cont_f = 0;
    if (ack_t.size() < 3) fail("back-to-back");
    else begin
      chk("ack spacing 1", 32'(ack_t[1] - ack_t[0]), 32'(L + 3));
      chk("ack spacing 2", 32'(ack_t[2] - ack_t[1]), 32'(L + 3));
    end
    drain();

    // randomized traffic with occasional resets
    rnd = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(399) == 0) do_reset();
      else tick();
    end
    rnd = 0;
    drain();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
